// File: rtl/ldpc_pkg.sv
// Shared types and helpers for the serial min-sum check-node unit.
package ldpc_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    PREP  = 2'd1,
    EMIT  = 2'd2
  } cnu_state_e;

  localparam int unsigned MAG_W = 32;

  // Largest positive value representable in a w-bit two's complement word.
  function automatic logic [MAG_W-1:0] max_mag(input int unsigned w);
    return (MAG_W'(1) << (w - 1)) - MAG_W'(1);
  endfunction

  // |x| for a w-bit value sign-extended to MAG_W; the most negative input clamps.
  function automatic logic [MAG_W-1:0] sat_mag(input logic [MAG_W-1:0] x,
                                               input int unsigned w);
    logic [MAG_W-1:0] m;
    m = x[MAG_W-1] ? (~x + MAG_W'(1)) : x;
    if (m > max_mag(w)) m = max_mag(w);
    return m;
  endfunction

endpackage

// File: rtl/ldpc_min2_tracker.sv
// Running min1/min2/min1-index/sign-parity register set for one check row.
module ldpc_min2_tracker #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] mag_i,
  input  logic             sign_i,
  input  logic [IDX_W-1:0] index_i,
  output logic [WIDTH-1:0] min1_o,
  output logic [WIDTH-1:0] min2_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             parity_o
);
  import ldpc_pkg::*;

  localparam logic [WIDTH-1:0] MAXM = WIDTH'(max_mag(WIDTH));

  logic [WIDTH-1:0] min1_q, min1_d, min2_q, min2_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             par_q, par_d;

  always_comb begin
    min1_d = min1_q;
    min2_d = min2_q;
    idx_d  = idx_q;
    par_d  = par_q;
    if (clear_i) begin
      min1_d = MAXM;
      min2_d = MAXM;
      idx_d  = '0;
      par_d  = 1'b0;
    end else if (valid_i) begin
      par_d = par_q ^ sign_i;
      // Strict compares: a tie keeps the earlier index and lands in min2.
      if (mag_i < min1_q) begin
        min2_d = min1_q;
        min1_d = mag_i;
        idx_d  = index_i;
      end else if (mag_i < min2_q) begin
        min2_d = mag_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min1_q <= MAXM;
      min2_q <= MAXM;
      idx_q  <= '0;
      par_q  <= 1'b0;
    end else begin
      min1_q <= min1_d;
      min2_q <= min2_d;
      idx_q  <= idx_d;
      par_q  <= par_d;
    end
  end

  assign min1_o   = min1_q;
  assign min2_o   = min2_q;
  assign idx_o    = idx_q;
  assign parity_o = par_q;

endmodule

// File: rtl/ldpc_check_node_serial.sv
// Serial min-sum check-node unit: one LLR in per cycle, then one LLR out per handshake.
// Define LDPC_CNU_OFFSET_EN to build the offset min-sum variant.
module ldpc_check_node_serial #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MAX_DEGREE = 32,
  parameter int unsigned OFFSET     = 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  input  logic             i_in_last,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_out_last,
  input  logic             i_out_ready,
  output logic             o_error
);
  import ldpc_pkg::*;

  localparam int unsigned CW = $clog2(MAX_DEGREE) + 1;
  localparam int unsigned IW = $clog2(MAX_DEGREE);
`ifdef LDPC_CNU_OFFSET_EN
  localparam int unsigned OFF_AMT = OFFSET;
`else
  localparam int unsigned OFF_AMT = OFFSET * 0;
`endif

  function automatic logic [WIDTH-1:0] apply_off(input logic [WIDTH-1:0] m);
    return (m > WIDTH'(OFF_AMT)) ? m - WIDTH'(OFF_AMT) : '0;
  endfunction

  cnu_state_e state_q, state_d;
  logic [CW-1:0]         cnt_q, deg_q, out_j_q, out_j_d, idx_q, tr_idx, src_idx, load_j;
  logic [MAX_DEGREE-1:0] sign_q;
  logic [WIDTH-1:0]      m1_q, m2_q, tr_min1, tr_min2, src_m1, src_m2, bmag, bval;
  logic [WIDTH-1:0]      in_mag, out_data_q, out_data_d;
  logic                  par_q, tr_par, src_par, bsign, blast;
  logic                  in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d, error_q, error_d;
  logic                  accept, row_end, hs;

  assign in_mag  = WIDTH'(sat_mag(MAG_W'($signed(i_in_data)), WIDTH));
  assign accept  = in_ready_q & i_in_valid;
  assign row_end = accept & (i_in_last | (cnt_q == CW'(MAX_DEGREE - 1)));
  assign hs      = out_valid_q & i_out_ready;

  ldpc_min2_tracker #(.WIDTH(WIDTH), .IDX_W(CW)) u_tracker (
    .clk_i    (i_clock),
    .rst_i    (i_reset),
    .clear_i  (state_q == PREP),
    .valid_i  (accept),
    .mag_i    (in_mag),
    .sign_i   (i_in_data[WIDTH-1]),
    .index_i  (cnt_q),
    .min1_o   (tr_min1),
    .min2_o   (tr_min2),
    .idx_o    (tr_idx),
    .parity_o (tr_par)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= ACCUM;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (row_end) state_d = PREP;
      PREP:    state_d = EMIT;
      EMIT:    if (hs && out_last_q) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // PREP builds beat 0 straight from the tracker while it is being captured and cleared.
  always_comb begin
    src_m1  = m1_q;
    src_m2  = m2_q;
    src_idx = idx_q;
    src_par = par_q;
    load_j  = out_j_q + CW'(1);
    if (state_q == PREP) begin
      src_m1  = apply_off(tr_min1);
      src_m2  = apply_off(tr_min2);
      src_idx = tr_idx;
      src_par = tr_par;
      load_j  = '0;
    end
    bmag  = (load_j == src_idx) ? src_m2 : src_m1;
    bsign = src_par ^ sign_q[load_j[IW-1:0]];
    bval  = bsign ? (~bmag + WIDTH'(1)) : bmag;
    blast = (load_j == deg_q - CW'(1));
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_j_d     = out_j_q;
    case (state_q)
      PREP: begin
        out_valid_d = 1'b1;
        out_data_d  = bval;
        out_last_d  = blast;
        out_j_d     = load_j;
      end
      EMIT: begin
        if (hs) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end else begin
            out_data_d = bval;
            out_last_d = blast;
            out_j_d    = load_j;
          end
        end
      end
      default: ;
    endcase
    in_ready_d = (state_d == ACCUM);
    error_d    = row_end & ~i_in_last;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q       <= '0;
      deg_q       <= '0;
      sign_q      <= '0;
      m1_q        <= '0;
      m2_q        <= '0;
      idx_q       <= '0;
      par_q       <= 1'b0;
      out_j_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      if (accept) begin
        sign_q[cnt_q[IW-1:0]] <= i_in_data[WIDTH-1];
        cnt_q <= row_end ? '0 : cnt_q + CW'(1);
        if (row_end) deg_q <= cnt_q + CW'(1);
      end
      if (state_q == PREP) begin
        m1_q  <= src_m1;
        m2_q  <= src_m2;
        idx_q <= src_idx;
        par_q <= src_par;
      end
      out_j_q     <= out_j_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      error_q     <= error_d;
    end
  end

  assign o_in_ready  = in_ready_q;
  assign o_out_data  = out_data_q;
  assign o_out_valid = out_valid_q;
  assign o_out_last  = out_last_q;
  assign o_error     = error_q;

endmodule
